// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light sequencer: register map,
// FSM encodings and the wait-value payload.
package traffic_pkg;

    localparam int unsigned WAIT_W = 3;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] A_T_R_WAIT = 2'h0;
    localparam logic [ADDR_W-1:0] A_T_G_WAIT = 2'h1;

    typedef enum logic [2:0] {
        F_IDLE,
        F_REQ_R,
        F_REL_R,
        F_REQ_G,
        F_REL_G
    } fetch_state_t;

    typedef enum logic [1:0] {
        L_RED,
        L_GREEN,
        L_YELLOW
    } light_state_t;

    typedef struct packed {
        logic [WAIT_W-1:0] r_wait;
        logic [WAIT_W-1:0] g_wait;
    } waits_t;

    // A programmed wait of zero still lasts one time unit.
    function automatic logic [WAIT_W-1:0] eff_wait(input logic [WAIT_W-1:0] w);
        return (w == '0) ? WAIT_W'(1) : w;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single-bit level crossing into the clk domain.
module sync2 (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/traffic_seq_ctrl.sv
// Traffic-light sequencer: fetches red/green waits from the SPI register file
// over a 4-phase handshake and runs RED -> GREEN -> YELLOW off a prescaled tick.
module traffic_seq_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned       TICK_DIV  = 1000,
    parameter int unsigned       YELLOW_T  = 2,
    parameter logic [WAIT_W-1:0] RED_DEF   = 3'd5,
    parameter logic [WAIT_W-1:0] GREEN_DEF = 3'd4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              done,
    input  logic              ren_ack,
    input  logic [WAIT_W-1:0] r_data,
    output logic              done_sync2,
    output logic              r_en,
    output logic [ADDR_W-1:0] r_addr,
    output logic              red,
    output logic              yellow,
    output logic              green
);

    localparam int unsigned     PS_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_MAX    = PS_W'(TICK_DIV - 1);
    localparam waits_t          DEF_WAITS = '{r_wait: RED_DEF, g_wait: GREEN_DEF};

    logic              ren_s2;
    logic              done_s2;
    logic              done_prev;
    logic              pending;
    fetch_state_t      f_state, f_next;
    logic              r_en_nxt;
    logic [ADDR_W-1:0] r_addr_nxt;
    logic              cap_red, cap_green;
    waits_t            shadow, active;
    logic [PS_W-1:0]   ps_cnt;
    logic              tick_c;
    light_state_t      l_state, l_next;
    logic [WAIT_W-1:0] unit_cnt, unit_nxt, phase_len_c;

    sync2 u_ren_sync  (.clk(clk), .n_rst(n_rst), .d(ren_ack), .q(ren_s2));
    sync2 u_done_sync (.clk(clk), .n_rst(n_rst), .d(done),    .q(done_s2));

    assign done_sync2 = done_s2;

    // A done edge arriving mid-fetch re-arms pending for one extra fetch.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            done_prev <= 1'b0;
            pending   <= 1'b0;
        end else begin
            done_prev <= done_s2;
            if (done_s2 && !done_prev) begin
                pending <= 1'b1;
            end else if (f_state == F_IDLE && pending) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        f_next     = f_state;
        r_en_nxt   = r_en;
        r_addr_nxt = r_addr;
        cap_red    = 1'b0;
        cap_green  = 1'b0;
        case (f_state)
            F_IDLE: if (pending) begin
                f_next     = F_REQ_R;
                r_addr_nxt = A_T_R_WAIT;
                r_en_nxt   = 1'b1;
            end
            F_REQ_R: if (ren_s2) begin
                cap_red  = 1'b1;
                r_en_nxt = 1'b0;
                f_next   = F_REL_R;
            end
            F_REL_R: if (!ren_s2) begin
                r_addr_nxt = A_T_G_WAIT;
                r_en_nxt   = 1'b1;
                f_next     = F_REQ_G;
            end
            F_REQ_G: if (ren_s2) begin
                cap_green = 1'b1;
                r_en_nxt  = 1'b0;
                f_next    = F_REL_G;
            end
            F_REL_G: if (!ren_s2) begin
                f_next = F_IDLE;
            end
            default: begin
                f_next   = F_IDLE;
                r_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            f_state <= F_IDLE;
            r_en    <= 1'b0;
            r_addr  <= A_T_R_WAIT;
            shadow  <= DEF_WAITS;
        end else begin
            f_state <= f_next;
            r_en    <= r_en_nxt;
            r_addr  <= r_addr_nxt;
            if (cap_red)   shadow.r_wait <= r_data;
            if (cap_green) shadow.g_wait <= r_data;
        end
    end

    assign tick_c = (ps_cnt == PS_MAX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= tick_c ? '0 : ps_cnt + PS_W'(1);
        end
    end

    always_comb begin
        l_next      = l_state;
        unit_nxt    = unit_cnt;
        phase_len_c = eff_wait(active.r_wait);
        case (l_state)
            L_GREEN:  phase_len_c = eff_wait(active.g_wait);
            L_YELLOW: phase_len_c = WAIT_W'(YELLOW_T);
            default:  phase_len_c = eff_wait(active.r_wait);
        endcase
        if (tick_c) begin
            if (unit_cnt + WAIT_W'(1) == phase_len_c) begin
                unit_nxt = '0;
                case (l_state)
                    L_RED:   l_next = L_GREEN;
                    L_GREEN: l_next = L_YELLOW;
                    default: l_next = L_RED;
                endcase
            end else begin
                unit_nxt = unit_cnt + WAIT_W'(1);
            end
        end
    end

    // New waits apply only on YELLOW -> RED, so a running phase is never altered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            l_state  <= L_RED;
            unit_cnt <= '0;
            active   <= DEF_WAITS;
            red      <= 1'b1;
            yellow   <= 1'b0;
            green    <= 1'b0;
        end else begin
            l_state  <= l_next;
            unit_cnt <= unit_nxt;
            if (l_state == L_YELLOW && l_next == L_RED) begin
                active <= shadow;
            end
            red    <= (l_next == L_RED);
            yellow <= (l_next == L_YELLOW);
            green  <= (l_next == L_GREEN);
        end
    end

endmodule

// File: tb/tb_traffic_seq_ctrl.sv
// Bench for traffic_seq_ctrl: register-file responder, phase-timing reference
// model and a directed/randomized sequence of fetch and reset scenarios.
module tb_traffic_seq_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned YELLOW_T = 2;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       done = 1'b0;
    logic       ren_ack = 1'b0;
    logic [2:0] r_data = 3'd0;
    logic       done_sync2, r_en, red, yellow, green;
    logic [1:0] r_addr;

    int n_tests = 0;
    int n_fail  = 0;

    int regs[2];
    int served[2];
    int done_req = 0;

    int   m_phase, m_units, m_cyc, m_act_r, m_act_g, m_sh_r, m_sh_g, m_s1, m_s2;
    logic prev_r_en;
    logic [1:0] prev_addr;
    int   fetch_starts = 0;
    int   fetch_dones = 0;
    int   proto_viol = 0;
    int   addr_seq[$];

    traffic_seq_ctrl #(
        .TICK_DIV (TICK_DIV),
        .YELLOW_T (YELLOW_T),
        .RED_DEF  (3'd5),
        .GREEN_DEF(3'd4)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .done      (done),
        .ren_ack   (ren_ack),
        .r_data    (r_data),
        .done_sync2(done_sync2),
        .r_en      (r_en),
        .r_addr    (r_addr),
        .red       (red),
        .yellow    (yellow),
        .green     (green)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int phase_len(input int ph, input int ar, input int ag);
        if (ph == 0) return (ar == 0) ? 1 : ar;
        if (ph == 1) return (ag == 0) ? 1 : ag;
        return int'(YELLOW_T);
    endfunction

    function automatic logic lamp(input int which);
        if (which == 0) return red;
        if (which == 1) return green;
        return yellow;
    endfunction

    // Reference model: phase timing from elapsed cycles; waits latched on red entry.
    initial begin : model
        logic [2:0] exp_lamps;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                m_phase = 0; m_units = 0; m_cyc = 0;
                m_act_r = 5; m_act_g = 4; m_sh_r = 5; m_sh_g = 4;
                m_s1 = 0; m_s2 = 0;
                prev_r_en = 1'b0; prev_addr = 2'd0;
            end else begin
                if ((m_cyc % int'(TICK_DIV)) == int'(TICK_DIV) - 1) begin
                    m_units++;
                    if (m_units == phase_len(m_phase, m_act_r, m_act_g)) begin
                        m_units = 0;
                        m_phase = (m_phase + 1) % 3;
                        if (m_phase == 0) begin
                            m_act_r = m_sh_r;
                            m_act_g = m_sh_g;
                        end
                    end
                end
                m_cyc++;
                m_s2 = m_s1;
                m_s1 = int'(done);
                if (prev_r_en && !r_en) begin
                    if (prev_addr == 2'd0) begin
                        m_sh_r = served[0];
                    end else begin
                        m_sh_g = served[1];
                        fetch_dones++;
                    end
                end
                if (r_en && !prev_r_en) begin
                    if (ren_ack) proto_viol++;
                    if (r_addr == 2'd0) fetch_starts++;
                    addr_seq.push_back(int'(r_addr));
                end
                if (r_en && prev_r_en && r_addr != prev_addr) proto_viol++;
                prev_r_en = r_en;
                prev_addr = r_addr;
            end
            exp_lamps = (m_phase == 0) ? 3'b100 : (m_phase == 1) ? 3'b001 : 3'b010;
            check("lamps", 32'({red, yellow, green}), 32'(exp_lamps));
            check("done_sync2", 32'(done_sync2), 32'(m_s2));
        end
    end

    // Register-file responder: 4-phase handshake with random latencies.
    initial begin : regfile
        int a;
        forever begin
            @(negedge clk);
            if (r_en) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                #3;
                a = (r_addr == 2'd1) ? 1 : 0;
                served[a] = regs[a];
                r_data    = 3'(regs[a]);
                ren_ack   = 1'b1;
                do @(negedge clk); while (r_en);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                #3;
                ren_ack = 1'b0;
            end
        end
    end

    initial begin : done_drv
        forever begin
            wait (done_req > 0);
            done_req--;
            @(negedge clk); #2;
            done = 1'b1;
            repeat (3) @(negedge clk);
            #2;
            done = 1'b0;
        end
    end

    // Length in cycles of the next run of the chosen lamp; fresh skips a run in progress.
    task automatic measure(input int which, input bit fresh, input bit kick, output int len);
        int g = 0;
        len = 0;
        if (fresh) while (lamp(which) && g < 2000) begin @(negedge clk); g++; end
        while (!lamp(which) && g < 2000) begin @(negedge clk); g++; end
        if (kick) done_req++;
        while (lamp(which) && g < 2000) begin len++; @(negedge clk); g++; end
        check("measure_bound", 32'((g >= 2000) ? 1 : 0), 32'd0);
    endtask

    task automatic wait_fetches(input int target, input string tag);
        int g = 0;
        while (fetch_dones < target && g < 800) begin @(negedge clk); g++; end
        check(tag, 32'((fetch_dones >= target) ? 1 : 0), 32'd1);
    endtask

    initial begin : main
        int len, s0, f0, g;
        regs[0] = 5; regs[1] = 4;
        served[0] = 5; served[1] = 4;

        repeat (3) @(negedge clk);
        #1;
        check("rst_red", 32'(red), 32'd1);
        check("rst_yellow", 32'(yellow), 32'd0);
        check("rst_green", 32'(green), 32'd0);
        check("rst_r_en", 32'(r_en), 32'd0);
        check("rst_r_addr", 32'(r_addr), 32'd0);
        check("rst_done_sync2", 32'(done_sync2), 32'd0);
        @(negedge clk); #2;
        n_rst = 1'b1;

        // Default timing with no done
        measure(1, 1'b0, 1'b0, len); check("def_green", 32'(len), 32'd16);
        measure(2, 1'b0, 1'b0, len); check("def_yellow", 32'(len), 32'd8);
        measure(0, 1'b0, 1'b0, len); check("def_red", 32'(len), 32'd20);

        // Fetch red=2 green=6
        regs[0] = 2; regs[1] = 6;
        addr_seq.delete();
        s0 = fetch_starts; f0 = fetch_dones;
        done_req++;
        g = 0;
        while (!done && g < 100) begin #1; g++; end
        check("done_seen", 32'(done), 32'd1);
        @(negedge clk); #1;
        check("sync_1clk", 32'(done_sync2), 32'd0);
        @(negedge clk); #1;
        check("sync_2clk", 32'(done_sync2), 32'd1);
        wait_fetches(f0 + 1, "fetch1_done");
        check("fetch1_starts", 32'(fetch_starts - s0), 32'd1);
        check("addr_seq_len", 32'(addr_seq.size()), 32'd2);
        if (addr_seq.size() >= 2) begin
            check("addr_seq0", 32'(addr_seq[0]), 32'd0);
            check("addr_seq1", 32'(addr_seq[1]), 32'd1);
        end
        measure(0, 1'b1, 1'b0, len); check("new_red", 32'(len), 32'd8);
        measure(1, 1'b0, 1'b0, len); check("new_green", 32'(len), 32'd24);

        // Fetch during green: the running green keeps its old length
        regs[0] = 3; regs[1] = 1;
        f0 = fetch_dones;
        measure(1, 1'b1, 1'b1, len); check("midgreen_keep", 32'(len), 32'd24);
        check("midgreen_fetched", 32'(fetch_dones - f0), 32'd1);
        measure(0, 1'b0, 1'b0, len); check("applied_red", 32'(len), 32'd12);
        measure(1, 1'b0, 1'b0, len); check("applied_green", 32'(len), 32'd4);

        // Zero wait behaves as one unit
        regs[0] = 0; regs[1] = 2;
        f0 = fetch_dones;
        done_req++;
        wait_fetches(f0 + 1, "zero_fetch");
        measure(0, 1'b1, 1'b0, len); check("zero_red", 32'(len), 32'd4);
        measure(1, 1'b0, 1'b0, len); check("zero_green", 32'(len), 32'd8);

        // Second done edge during the green read yields exactly one extra fetch
        regs[0] = int'($urandom_range(0, 7)); regs[1] = int'($urandom_range(0, 7));
        s0 = fetch_starts; f0 = fetch_dones;
        done_req++;
        g = 0;
        while (!(r_en && r_addr == 2'd1) && g < 300) begin @(negedge clk); g++; end
        check("reach_req_g", 32'((r_en && r_addr == 2'd1) ? 1 : 0), 32'd1);
        done_req++;
        wait_fetches(f0 + 2, "refetch_done");
        repeat (40) @(negedge clk);
        check("refetch_starts", 32'(fetch_starts - s0), 32'd2);

        // Randomized configs and done timing against the model
        for (int i = 0; i < 6; i++) begin
            regs[0] = int'($urandom_range(0, 7));
            regs[1] = int'($urandom_range(0, 7));
            repeat ($urandom_range(0, 40)) @(negedge clk);
            f0 = fetch_dones;
            done_req++;
            wait_fetches(f0 + 1, "rand_fetch");
            repeat (5) @(negedge clk);
        end
        repeat (150) @(negedge clk);

        // Reset in the middle of a fetch
        regs[0] = 1; regs[1] = 1;
        done_req++;
        g = 0;
        while (!r_en && g < 300) begin @(negedge clk); g++; end
        check("pre_rst_r_en", 32'(r_en), 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_mid_r_en", 32'(r_en), 32'd0);
        check("rst_mid_red", 32'(red), 32'd1);
        check("rst_mid_green", 32'(green), 32'd0);
        check("rst_mid_yellow", 32'(yellow), 32'd0);
        repeat (3) @(negedge clk);
        #2;
        s0 = fetch_starts;
        n_rst = 1'b1;
        measure(0, 1'b0, 1'b0, len); check("post_rst_red", 32'(len), 32'd20);
        measure(1, 1'b0, 1'b0, len); check("post_rst_green", 32'(len), 32'd16);
        check("post_rst_no_fetch", 32'(fetch_starts - s0), 32'd0);
        check("protocol", 32'(proto_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
